mod_mem_access_unit: RTL and testbench

Memory-stage access controller between the pipeline's MEM stage and the data-memory bus. Accepts one load or store per handshake, checks alignment, drives a word-aligned bus request with byte enables and lane-replicated store data, waits out bus wait states and read latency, then presents the raw read word with its unaligned address and funct3 to the downstream load-data aligner. One transaction in flight at a time.

---
 rtl/mem_access_pkg.sv | 38 +++
 rtl/mod_mem_store_data_aligner.sv | 37 +++
 rtl/mod_mem_access_unit.sv | 199 +++++++++++++++++++
 tb/tb_mod_mem_access_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory-stage access unit.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_TIMEOUT  = 2'd2
  } fault_e;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // RV32 load/store width codes.
  localparam logic [`FUNCT3_WIDTH-1:0] F3_LB  = 3'b000;
  localparam logic [`FUNCT3_WIDTH-1:0] F3_LH  = 3'b001;
  localparam logic [`FUNCT3_WIDTH-1:0] F3_LW  = 3'b010;
  localparam logic [`FUNCT3_WIDTH-1:0] F3_LBU = 3'b100;
  localparam logic [`FUNCT3_WIDTH-1:0] F3_LHU = 3'b101;
  localparam logic [`FUNCT3_WIDTH-1:0] F3_SB  = 3'b000;
  localparam logic [`FUNCT3_WIDTH-1:0] F3_SH  = 3'b001;
  localparam logic [`FUNCT3_WIDTH-1:0] F3_SW  = 3'b010;

endpackage

// File: rtl/mod_mem_store_data_aligner.sv
// Store lane steering: derives byte enables and lane-replicated write data
// from the store width code and the low address bits.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

module mod_mem_store_data_aligner
  import mem_access_pkg::*;
(
  input  logic [`FUNCT3_WIDTH-1:0] funct3,
  input  logic [1:0]               offset,
  input  logic [`XLEN-1:0]         data,
  output logic [3:0]               byteenable,
  output logic [`XLEN-1:0]         writedata
);

  // Replicate the operand across every lane it could land in; the enables pick the real one.
  always_comb begin
    byteenable = BE_WORD;
    writedata  = data;
    case (funct3)
      F3_SB: begin
        byteenable = BE_BYTE << offset;
        writedata  = {4{data[7:0]}};
      end
      F3_SH: begin
        byteenable = BE_HALF << offset;
        writedata  = {2{data[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mod_mem_access_unit.sv
// Memory-stage access controller: one load/store in flight, alignment check,
// word-aligned bus request, read-latency wait with timeout, one-cycle response.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef FUNCT3_WIDTH
`define FUNCT3_WIDTH 3
`endif

module mod_mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int RSP_TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_is_store_i,
  input  logic [`FUNCT3_WIDTH-1:0] funct3_i,
  input  logic [`XLEN-1:0]         addr_i,
  input  logic [`XLEN-1:0]         store_data_i,
  output logic [`XLEN-1:0]         mem_address_o,
  output logic                     mem_read_o,
  output logic                     mem_write_o,
  output logic [3:0]               mem_byteenable_o,
  output logic [`XLEN-1:0]         mem_writedata_o,
  input  logic                     mem_waitrequest_i,
  input  logic [`XLEN-1:0]         mem_readdata_i,
  input  logic                     mem_readdatavalid_i,
  output logic                     rsp_valid_o,
  output logic [`FUNCT3_WIDTH-1:0] rsp_funct3_o,
  output logic [`XLEN-1:0]         rsp_address_o,
  output logic [`XLEN-1:0]         rsp_readdata_o,
  output logic [1:0]               rsp_fault_o,
  output logic                     busy_o
);

  localparam logic [15:0] TMO_LAST = 16'(RSP_TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic                      ready_q;
  logic                      accept;
  logic                      in_issue;
  logic [15:0]               tmo_cnt_q;

  logic                      req_is_store_p0;
  logic [`FUNCT3_WIDTH-1:0]  req_funct3_p0;
  logic [`XLEN-1:0]          req_addr_p0;
  logic [`XLEN-1:0]          req_data_p0;

  logic                      rsp_load;
  fault_e                    rsp_fault_d;
  logic [`XLEN-1:0]          rsp_data_d;
  logic [`XLEN-1:0]          rsp_addr_d;
  logic [`FUNCT3_WIDTH-1:0]  rsp_f3_d;

  logic [`FUNCT3_WIDTH-1:0]  rsp_funct3_p1;
  logic [`XLEN-1:0]          rsp_address_p1;
  logic [`XLEN-1:0]          rsp_readdata_p1;
  fault_e                    rsp_fault_p1;

  logic [3:0]                al_be;
  logic [`XLEN-1:0]          al_wdata;

  // A request is refused when its width code is illegal or its address is
  // not naturally aligned for that width.
  function automatic logic is_bad_req(input logic                     is_store,
                                      input logic [`FUNCT3_WIDTH-1:0] f3,
                                      input logic [1:0]               off);
    logic bad;
    bad = 1'b1;
    if (is_store) begin
      case (f3)
        F3_SB:   bad = 1'b0;
        F3_SH:   bad = off[0];
        F3_SW:   bad = (off != 2'b00);
        default: bad = 1'b1;
      endcase
    end else begin
      case (f3)
        F3_LB, F3_LBU: bad = 1'b0;
        F3_LH, F3_LHU: bad = off[0];
        F3_LW:         bad = (off != 2'b00);
        default:       bad = 1'b1;
      endcase
    end
    return bad;
  endfunction

  assign accept   = (state_q == IDLE) && ready_q && req_valid_i;
  assign in_issue = (state_q == ISSUE);

  // Next-state and response-capture decode.
  always_comb begin
    state_d     = state_q;
    rsp_load    = 1'b0;
    rsp_fault_d = FAULT_NONE;
    rsp_data_d  = '0;
    rsp_f3_d    = (state_q == IDLE) ? funct3_i : req_funct3_p0;
    rsp_addr_d  = (state_q == IDLE) ? addr_i   : req_addr_p0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_bad_req(req_is_store_i, funct3_i, addr_i[1:0])) begin
            state_d     = RESP;
            rsp_load    = 1'b1;
            rsp_fault_d = FAULT_MISALIGN;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!mem_waitrequest_i) begin
          if (req_is_store_p0) begin
            state_d  = RESP;
            rsp_load = 1'b1;
          end else begin
            state_d = WAIT_RD;
          end
        end
      end
      WAIT_RD: begin
        if (mem_readdatavalid_i) begin
          state_d    = RESP;
          rsp_load   = 1'b1;
          rsp_data_d = mem_readdata_i;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = RESP;
          rsp_load    = 1'b1;
          rsp_fault_d = FAULT_TIMEOUT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state: FSM, ready flag (low through reset) and read timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      tmo_cnt_q <= (state_q == WAIT_RD) ? tmo_cnt_q + 16'd1 : 16'd0;
    end
  end

  // Stage p0: request fields captured at the handshake.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_is_store_p0 <= req_is_store_i;
      req_funct3_p0   <= funct3_i;
      req_addr_p0     <= addr_i;
      req_data_p0     <= store_data_i;
    end
  end

  // Stage p1: response fields, updated only on entry to RESP and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_funct3_p1   <= '0;
      rsp_address_p1  <= '0;
      rsp_readdata_p1 <= '0;
      rsp_fault_p1    <= FAULT_NONE;
    end else if (rsp_load) begin
      rsp_funct3_p1   <= rsp_f3_d;
      rsp_address_p1  <= rsp_addr_d;
      rsp_readdata_p1 <= rsp_data_d;
      rsp_fault_p1    <= rsp_fault_d;
    end
  end

  mod_mem_store_data_aligner u_store_aligner (
    .funct3     (req_funct3_p0),
    .offset     (req_addr_p0[1:0]),
    .data       (req_data_p0),
    .byteenable (al_be),
    .writedata  (al_wdata)
  );

  assign req_ready_o      = ready_q;
  assign busy_o           = (state_q != IDLE);
  assign mem_read_o       = in_issue && !req_is_store_p0;
  assign mem_write_o      = in_issue && req_is_store_p0;
  assign mem_address_o    = in_issue ? {req_addr_p0[`XLEN-1:2], 2'b00} : '0;
  assign mem_byteenable_o = in_issue ? (req_is_store_p0 ? al_be : BE_WORD) : 4'b0000;
  assign mem_writedata_o  = (in_issue && req_is_store_p0) ? al_wdata : '0;
  assign rsp_valid_o      = (state_q == RESP);
  assign rsp_funct3_o     = rsp_funct3_p1;
  assign rsp_address_o    = rsp_address_p1;
  assign rsp_readdata_o   = rsp_readdata_p1;
  assign rsp_fault_o      = rsp_fault_p1;

endmodule

// File: tb/tb_mod_mem_access_unit.sv
// Self-checking bench for mod_mem_access_unit with a response scoreboard.
`timescale 1ns/1ps

module tb_mod_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_i, req_ready_o, req_is_store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic [31:0] mem_address_o;
  logic        mem_read_o, mem_write_o;
  logic [3:0]  mem_byteenable_o;
  logic [31:0] mem_writedata_o;
  logic        mem_waitrequest_i;
  logic [31:0] mem_readdata_i;
  logic        mem_readdatavalid_i;
  logic        rsp_valid_o;
  logic [2:0]  rsp_funct3_o;
  logic [31:0] rsp_address_o, rsp_readdata_o;
  logic [1:0]  rsp_fault_o;
  logic        busy_o;

  always #5 clk = ~clk;

  mod_mem_access_unit #(.RSP_TIMEOUT(TMO)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_is_store_i      (req_is_store_i),
    .funct3_i            (funct3_i),
    .addr_i              (addr_i),
    .store_data_i        (store_data_i),
    .mem_address_o       (mem_address_o),
    .mem_read_o          (mem_read_o),
    .mem_write_o         (mem_write_o),
    .mem_byteenable_o    (mem_byteenable_o),
    .mem_writedata_o     (mem_writedata_o),
    .mem_waitrequest_i   (mem_waitrequest_i),
    .mem_readdata_i      (mem_readdata_i),
    .mem_readdatavalid_i (mem_readdatavalid_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_funct3_o        (rsp_funct3_o),
    .rsp_address_o       (rsp_address_o),
    .rsp_readdata_o      (rsp_readdata_o),
    .rsp_fault_o         (rsp_fault_o),
    .busy_o              (busy_o)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Values observed by run_txn for the test tasks to judge.
  logic        o_done, o_stable, o_valid_after, o_ready_after;
  int          o_cycles, o_strobe_cnt;
  logic [31:0] o_addr, o_wdata, o_rdata, o_raddr;
  logic [3:0]  o_be;
  logic [2:0]  o_f3;
  logic [1:0]  o_fault;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one request and acts as the bus until the response pulse (bounded).
  task automatic run_txn(input logic is_store, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] data, input int waits, input int lat,
                         input logic [31:0] rdata, input logic drop);
    int   wait_left, rdv_cyc;
    logic first;
    o_done = 0; o_stable = 1; o_cycles = -1; o_strobe_cnt = 0; first = 1;
    o_addr = '0; o_be = '0; o_wdata = '0;
    wait_left = waits; rdv_cyc = -1;
    req_valid_i = 1; req_is_store_i = is_store; funct3_i = f3; addr_i = addr; store_data_i = data;
    tick();
    req_valid_i = 0;
    for (int cyc = 1; cyc <= 300 && !o_done; cyc++) begin
      mem_readdatavalid_i = (cyc == rdv_cyc) && !drop;
      mem_readdata_i      = mem_readdatavalid_i ? rdata : 32'hFFFF_FFFF;
      mem_waitrequest_i   = 0;
      if (mem_read_o || mem_write_o) begin
        if (first) begin
          o_addr = mem_address_o; o_be = mem_byteenable_o; o_wdata = mem_writedata_o; first = 0;
        end else if (mem_address_o !== o_addr || mem_byteenable_o !== o_be ||
                     mem_writedata_o !== o_wdata) begin
          o_stable = 0;
        end
        o_strobe_cnt++;
        if (wait_left > 0) begin
          mem_waitrequest_i = 1;
          wait_left--;
        end else if (mem_read_o) begin
          rdv_cyc = cyc + lat;
        end
      end
      if (rsp_valid_o) begin
        o_done = 1; o_cycles = cyc;
        o_f3 = rsp_funct3_o; o_raddr = rsp_address_o; o_rdata = rsp_readdata_o; o_fault = rsp_fault_o;
      end
      if (!o_done) tick();
    end
    mem_readdatavalid_i = 0; mem_waitrequest_i = 0; mem_readdata_i = '0;
    tick();
    o_valid_after = rsp_valid_o;
    o_ready_after = req_ready_o;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) tick();
    checks++;
    if ({req_ready_o, mem_read_o, mem_write_o, rsp_valid_o, busy_o, rsp_fault_o,
         mem_byteenable_o, mem_address_o, mem_writedata_o, rsp_readdata_o, rsp_address_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready=%b rd=%b wr=%b vld=%b busy=%b, required all 0",
               req_ready_o, mem_read_o, mem_write_o, rsp_valid_o, busy_o);
    end
    rst = 0;
    tick();
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b required 1", req_ready_o);
    end
  endtask

  task automatic test_load_word();
    exp_t e;
    sb_q.push_back('{3'b010, 32'h1000, 32'hDEAD_BEEF, 2'd0});
    run_txn(1'b0, 3'b010, 32'h1000, 32'h0, 0, 1, 32'hDEAD_BEEF, 1'b0);
    e = sb_q.pop_front();
    checks++;
    if (!o_done) begin errors++; $display("FAIL lw_done: no rsp_valid within budget"); end
    checks++;
    if (o_addr !== 32'h1000 || o_be !== 4'b1111) begin
      errors++; $display("FAIL lw_bus: got addr=%h be=%b required 00001000/1111", o_addr, o_be);
    end
    checks++;
    if (o_cycles !== 3) begin errors++; $display("FAIL lw_latency: got %0d required 3", o_cycles); end
    checks++;
    if ({o_f3, o_raddr, o_rdata, o_fault} !== {e.f3, e.addr, e.data, e.fault}) begin
      errors++;
      $display("FAIL lw_rsp: got f3=%h a=%h d=%h f=%0d required f3=%h a=%h d=%h f=%0d",
               o_f3, o_raddr, o_rdata, o_fault, e.f3, e.addr, e.data, e.fault);
    end
    checks++;
    if (o_valid_after !== 1'b0 || o_ready_after !== 1'b1) begin
      errors++; $display("FAIL lw_pulse: got vld=%b rdy=%b after rsp required 0/1", o_valid_after, o_ready_after);
    end
  endtask

  task automatic test_store_lanes();
    logic [2:0]  t_f3[3]    = '{3'b000, 3'b001, 3'b010};
    logic [31:0] t_addr[3]  = '{32'h2003, 32'h2002, 32'h2004};
    logic [31:0] t_data[3]  = '{32'h0000_00A5, 32'h1234_BEEF, 32'h1122_3344};
    int          t_wait[3]  = '{3, 0, 1};
    logic [3:0]  t_be[3]    = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] t_wd[3]    = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h1122_3344};
    logic [31:0] t_ma[3]    = '{32'h2000, 32'h2000, 32'h2004};
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back('{t_f3[i], t_addr[i], 32'h0, 2'd0});
      run_txn(1'b1, t_f3[i], t_addr[i], t_data[i], t_wait[i], 1, 32'h0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (o_addr !== t_ma[i] || o_be !== t_be[i] || o_wdata !== t_wd[i]) begin
        errors++;
        $display("FAIL st%0d_bus: got addr=%h be=%b wd=%h required %h/%b/%h",
                 i, o_addr, o_be, o_wdata, t_ma[i], t_be[i], t_wd[i]);
      end
      checks++;
      if (!o_stable || o_strobe_cnt !== t_wait[i] + 1) begin
        errors++;
        $display("FAIL st%0d_hold: got stable=%b strobes=%0d required 1/%0d", i, o_stable, o_strobe_cnt, t_wait[i] + 1);
      end
      checks++;
      if (o_cycles !== t_wait[i] + 2) begin
        errors++; $display("FAIL st%0d_latency: got %0d required %0d", i, o_cycles, t_wait[i] + 2);
      end
      checks++;
      if ({o_f3, o_raddr, o_rdata, o_fault} !== {e.f3, e.addr, e.data, e.fault} || o_valid_after !== 1'b0) begin
        errors++;
        $display("FAIL st%0d_rsp: got f3=%h a=%h d=%h f=%0d vld_after=%b required f3=%h a=%h d=0 f=0 vld_after=0",
                 i, o_f3, o_raddr, o_rdata, o_fault, o_valid_after, e.f3, e.addr);
      end
    end
  endtask

  task automatic test_fault();
    logic        t_st[4]   = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0]  t_f3[4]   = '{3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] t_addr[4] = '{32'h2001, 32'h1002, 32'h1000, 32'h2000};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back('{t_f3[i], t_addr[i], 32'h0, 2'd1});
      run_txn(t_st[i], t_f3[i], t_addr[i], 32'h5555_AAAA, 0, 1, 32'h0, 1'b0);
      e = sb_q.pop_front();
      checks++;
      if (o_cycles !== 1 || o_strobe_cnt !== 0) begin
        errors++; $display("FAIL fault%0d_timing: got cycle=%0d strobes=%0d required 1/0", i, o_cycles, o_strobe_cnt);
      end
      checks++;
      if ({o_f3, o_raddr, o_rdata, o_fault} !== {e.f3, e.addr, e.data, e.fault}) begin
        errors++;
        $display("FAIL fault%0d_rsp: got f3=%h a=%h d=%h f=%0d required f3=%h a=%h d=0 f=1",
                 i, o_f3, o_raddr, o_rdata, o_fault, e.f3, e.addr);
      end
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    sb_q.push_back('{3'b100, 32'h3002, 32'h0, 2'd2});
    run_txn(1'b0, 3'b100, 32'h3002, 32'h0, 0, 1, 32'h1234_5678, 1'b1);
    e = sb_q.pop_front();
    checks++;
    if (!o_done || o_cycles < TMO + 1 || o_cycles > TMO + 3) begin
      errors++; $display("FAIL tmo_latency: got done=%b cycle=%0d required %0d..%0d", o_done, o_cycles, TMO + 1, TMO + 3);
    end
    checks++;
    if ({o_f3, o_raddr, o_rdata, o_fault} !== {e.f3, e.addr, e.data, e.fault} || o_addr !== 32'h3000) begin
      errors++;
      $display("FAIL tmo_rsp: got f3=%h a=%h d=%h f=%0d bus=%h required f3=4 a=00003002 d=0 f=2 bus=00003000",
               o_f3, o_raddr, o_rdata, o_fault, o_addr);
    end
    checks++;
    if (o_ready_after !== 1'b1 || rsp_address_o !== 32'h3002 || rsp_fault_o !== 2'd2) begin
      errors++;
      $display("FAIL tmo_hold: got rdy=%b a=%h f=%0d required 1/00003002/2", o_ready_after, rsp_address_o, rsp_fault_o);
    end
    // Data arriving on the final wait cycle still completes cleanly.
    sb_q.push_back('{3'b010, 32'h3004, 32'hCAFE_0001, 2'd0});
    run_txn(1'b0, 3'b010, 32'h3004, 32'h0, 0, TMO, 32'hCAFE_0001, 1'b0);
    e = sb_q.pop_front();
    checks++;
    if ({o_f3, o_raddr, o_rdata, o_fault} !== {e.f3, e.addr, e.data, e.fault}) begin
      errors++;
      $display("FAIL late_data_rsp: got d=%h f=%0d required d=%h f=0", o_rdata, o_fault, e.data);
    end
  endtask

  task automatic test_reset_mid();
    logic saw_vld;
    req_valid_i = 1; req_is_store_i = 0; funct3_i = 3'b010; addr_i = 32'h5000; store_data_i = '0;
    tick();
    req_valid_i = 0;
    tick();
    checks++;
    if (busy_o !== 1'b1 || mem_read_o !== 1'b0) begin
      errors++; $display("FAIL mid_wait_state: got busy=%b rd=%b required 1/0", busy_o, mem_read_o);
    end
    rst = 1;
    tick();
    rst = 0;
    saw_vld = 0;
    mem_readdatavalid_i = 1; mem_readdata_i = 32'h7777_7777;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid_o || mem_read_o || mem_write_o || busy_o) saw_vld = 1;
      tick();
      mem_readdatavalid_i = 0;
    end
    checks++;
    if (saw_vld !== 1'b0) begin
      errors++; $display("FAIL mid_reset_quiet: got activity=%b required 0", saw_vld);
    end
    checks++;
    if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_idle: got rdy=%b busy=%b required 1/0", req_ready_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   r1, r2, a2;
    logic prev_read, overlap;
    logic [3:0] be2;
    r1 = -1; r2 = -1; a2 = -1; prev_read = 0; overlap = 0; be2 = '0;
    sb_q.push_back('{3'b010, 32'h4000, 32'h0, 2'd0});
    sb_q.push_back('{3'b001, 32'h4002, 32'h5566_7788, 2'd0});
    req_valid_i = 1; req_is_store_i = 1; funct3_i = 3'b010; addr_i = 32'h4000; store_data_i = 32'hCAFE_F00D;
    tick();
    req_is_store_i = 0; funct3_i = 3'b001; addr_i = 32'h4002; store_data_i = '0;
    for (int cyc = 1; cyc <= 40 && r2 < 0; cyc++) begin
      if (a2 >= 0 && cyc == a2 + 1) req_valid_i = 0;
      mem_waitrequest_i   = 0;
      mem_readdatavalid_i = prev_read;
      mem_readdata_i      = prev_read ? 32'h5566_7788 : 32'hFFFF_FFFF;
      prev_read           = mem_read_o;
      if (mem_read_o) be2 = mem_byteenable_o;
      if (busy_o && req_ready_o) overlap = 1;
      if (req_ready_o && req_valid_i && a2 < 0) a2 = cyc;
      if (rsp_valid_o) begin
        e = sb_q.pop_front();
        checks++;
        if ({rsp_funct3_o, rsp_address_o, rsp_readdata_o, rsp_fault_o} !== {e.f3, e.addr, e.data, e.fault}) begin
          errors++;
          $display("FAIL b2b_rsp: got f3=%h a=%h d=%h f=%0d required f3=%h a=%h d=%h f=%0d",
                   rsp_funct3_o, rsp_address_o, rsp_readdata_o, rsp_fault_o, e.f3, e.addr, e.data, e.fault);
        end
        if (r1 < 0) r1 = cyc; else r2 = cyc;
      end
      tick();
    end
    req_valid_i = 0; mem_readdatavalid_i = 0;
    checks++;
    if (r1 !== 2 || a2 !== 3 || r2 !== 6) begin
      errors++; $display("FAIL b2b_timing: got rsp1=%0d accept2=%0d rsp2=%0d required 2/3/6", r1, a2, r2);
    end
    checks++;
    if (overlap !== 1'b0 || be2 !== 4'b1111) begin
      errors++; $display("FAIL b2b_ready_be: got overlap=%b be=%b required 0/1111", overlap, be2);
    end
    checks++;
    if (sb_q.size() !== 0) begin
      errors++; $display("FAIL b2b_scoreboard: got %0d pending required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    rst = 1; req_valid_i = 0; req_is_store_i = 0; funct3_i = '0; addr_i = '0; store_data_i = '0;
    mem_waitrequest_i = 0; mem_readdata_i = '0; mem_readdatavalid_i = 0;
    #1;
    test_reset();
    test_load_word();
    test_store_lanes();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
